// File: rtl/jtframe_sdram_arb_pkg.sv
// jtframe_sdram_arb_pkg
// Shared types and constants for the SDRAM read arbiter and its per-slot caches.
//   state_t : arbiter FSM states (IDLE, REQ, WAIT)
//   DEF_AW  : default SDRAM word address width
//   DEF_DW  : default read data width
//   tag_w() : cache tag width, which is the word address plus the 2-bit bank
package jtframe_sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEF_AW = 22;
  localparam int DEF_DW = 32;

  function automatic int tag_w(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/jtframe_sdram_arb_slot.sv
// jtframe_sdram_arb_slot
// One-word read cache for a single ROM requester. It stores the tag, the data
// and a valid bit. The hit compare is combinational, so a hit costs no latency.
// Ports:
//   clk_rom, rst : clock and synchronous active-high reset
//   i_flush      : clears the valid bit; this takes priority over a write
//   i_cs         : requester chip-select
//   i_addr       : requester word address
//   i_bank       : requester bank
//   i_wr         : write strobe from the arbiter
//   i_wr_tag     : tag captured when the request was granted
//   i_wr_data    : data returned by SDRAM
//   o_ok         : o_dout is valid for the current {i_bank, i_addr}
//   o_dout       : cached data word
module jtframe_sdram_arb_slot
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic                  clk_rom,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_cs,
  input  logic [AW-1:0]         i_addr,
  input  logic [1:0]            i_bank,
  input  logic                  i_wr,
  input  logic [tag_w(AW)-1:0]  i_wr_tag,
  input  logic [DW-1:0]         i_wr_data,
  output logic                  o_ok,
  output logic [DW-1:0]         o_dout
);

  localparam int TW = tag_w(AW);

  logic [TW-1:0] r_tag;
  logic [DW-1:0] r_data;
  logic          r_valid;

  // NOTE: sequential state uses non-blocking assignments only. Blocking
  // assignments here would create ordering races with the other flops.
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      r_valid <= 1'b0;
      // NOTE: the data word is reset as well, so the output reads as zero
      // after reset. A pure cache would only need the valid bit reset.
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_tag   <= i_wr_tag;
      r_data  <= i_wr_data;
    end
  end

  assign o_ok   = i_cs & r_valid & (r_tag == {i_bank, i_addr});
  assign o_dout = r_data;

endmodule

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb
// Read arbiter between SLOTS ROM requesters and the single SDRAM read port.
// A slot that misses its cache becomes pending. The FSM grants one pending slot
// and runs the req/ack/rdy handshake with the controller. The returned word is
// then written into that slot's cache, together with the tag captured at grant.
// All logic runs in the clk_rom domain.
// Ports:
//   clk_rom, rst          : clock and synchronous active-high reset
//   downloading           : ROM download; flushes caches, blocks new grants
//   slot_addr/bank/cs     : packed per-slot requests (slot i at [i*W +: W])
//   slot_ok/slot_dout     : packed per-slot hit flag and cached data
//   sdram_req/addr/bank   : request to the SDRAM controller
//   sdram_ack, data_rdy   : one-cycle pulses from the controller
//   data_read             : SDRAM read data
//   refresh_en            : arbiter idle and nothing pending
// Build option JTFRAME_SDRAM_ARB_RR_EN: round-robin grant that starts its search
// one slot past the last grant. Without it, the grant is fixed priority and
// slot 0 has the highest priority.
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                  clk_rom,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  input  logic [SLOTS*2-1:0]    slot_bank,
  input  logic [SLOTS-1:0]      slot_cs,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*DW-1:0]   slot_dout,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic [AW-1:0]         sdram_addr,
  output logic [1:0]            sdram_bank,
  input  logic [DW-1:0]         data_read,
  input  logic                  data_rdy,
  output logic                  refresh_en
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int TW = tag_w(AW);

  state_t         r_state,   w_state_nxt;
  logic           r_req,     w_req_nxt;
  logic [AW-1:0]  r_addr,    w_addr_nxt;
  logic [1:0]     r_bank,    w_bank_nxt;
  logic [IW-1:0]  r_gnt,     w_gnt_nxt;
  logic [TW-1:0]  r_tag,     w_tag_nxt;
  logic           r_discard, w_discard_nxt;

  logic [SLOTS-1:0] w_ok, w_pending, w_wr;
  logic             w_done;
  logic             w_any;
  logic [IW-1:0]    w_win;

  assign w_pending = slot_cs & ~w_ok & {SLOTS{~downloading}};
  assign w_any     = |w_pending;

`ifdef JTFRAME_SDRAM_ARB_RR_EN
  logic [IW-1:0] r_last;

  always_comb begin
    int idx;
    logic found;
    w_win = r_last;
    found = 1'b0;
    // The search starts one past the last grant, so the last winner is tried last.
    for (int k = 1; k <= SLOTS; k++) begin
      idx = (int'(r_last) + k) % SLOTS;
      if (!found && w_pending[idx]) begin
        w_win = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rom) begin
    if (rst)                           r_last <= '0;
    else if (r_state == IDLE && w_any) r_last <= w_win;
  end
`else
  always_comb begin
    w_win = '0;
    // Walk downwards so that the lowest pending index is the one left standing.
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (w_pending[k]) w_win = IW'(k);
    end
  end
`endif

  // NOTE: every signal assigned in this block gets a default first. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_addr_nxt    = r_addr;
    w_bank_nxt    = r_bank;
    w_gnt_nxt     = r_gnt;
    w_tag_nxt     = r_tag;
    // A download seen at any point of a transaction drops its cache write.
    w_discard_nxt = r_discard | downloading;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        w_discard_nxt = 1'b0;
        if (w_any) begin
          w_addr_nxt  = slot_addr[w_win*AW +: AW];
          w_bank_nxt  = slot_bank[w_win*2 +: 2];
          w_tag_nxt   = {w_bank_nxt, w_addr_nxt};
          w_gnt_nxt   = w_win;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          w_req_nxt = 1'b0;
          // Data can arrive together with the ack; close the transaction here.
          if (data_rdy) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (data_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_bank    <= '0;
      r_gnt     <= '0;
      r_tag     <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
      r_bank    <= w_bank_nxt;
      r_gnt     <= w_gnt_nxt;
      r_tag     <= w_tag_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    // The flush input also blocks a write if the download is still active.
    assign w_wr[i] = w_done & ~r_discard & (r_gnt == IW'(i));

    jtframe_sdram_arb_slot #(
      .AW (AW),
      .DW (DW)
    ) u_slot (
      .clk_rom   (clk_rom),
      .rst       (rst),
      .i_flush   (downloading),
      .i_cs      (slot_cs[i]),
      .i_addr    (slot_addr[i*AW +: AW]),
      .i_bank    (slot_bank[i*2 +: 2]),
      .i_wr      (w_wr[i]),
      .i_wr_tag  (r_tag),
      .i_wr_data (data_read),
      .o_ok      (w_ok[i]),
      .o_dout    (slot_dout[i*DW +: DW])
    );
  end

  assign slot_ok    = w_ok;
  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;
  assign sdram_bank = r_bank;
  assign refresh_en = (r_state == IDLE) & ~w_any;

endmodule
